// File: rtl/logic_analyser_capture_if.sv
// rtl/logic_analyser_capture_if.sv - probe/output bus of the logic-analyser capture channel
// master drives the probe and observes the output; slave is the capture block.
interface logic_analyser_capture_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] io_in0;
  logic [WIDTH-1:0] io_out0;

  modport master (output io_in0, input io_out0);
  modport slave (input io_in0, output io_out0);
endinterface

// File: rtl/logic_analyser_capture.sv
// rtl/logic_analyser_capture.sv - single-channel trigger, capture and cyclic replay
// Arms on reset, captures DEPTH samples from the first probe change, then replays them forever.
module logic_analyser_capture #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  logic_analyser_capture_if.slave   io_bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    REPLAY  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_out_q;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] w_sample;
  assign w_sample       = io_bus.io_in0;
  assign io_bus.io_out0 = r_out_q;

  // Capture memory is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ARMED;
      r_prev   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_out_q  <= '0;
    end else begin
      case (r_state)
        ARMED: begin
          r_prev  <= w_sample;
          r_out_q <= w_sample;
          if (w_sample != r_prev) begin
            r_mem[0] <= w_sample;
            r_wr_ptr <= AW'(1);
            r_state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_mem[r_wr_ptr] <= w_sample;
          r_prev          <= w_sample;
          r_out_q         <= w_sample;
          r_wr_ptr        <= r_wr_ptr + AW'(1);
          if (r_wr_ptr == AW'(DEPTH - 1)) begin
            r_rd_ptr <= '0;
            r_state  <= REPLAY;
          end
        end
        REPLAY: begin
          r_out_q  <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        default: r_state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_analyser_capture.sv
// tb/tb_logic_analyser_capture.sv - self-checking bench for logic_analyser_capture
// Model: output at edge n is the sample at trigger + (n - trigger) mod DEPTH, else the live sample.
module tb_logic_analyser_capture;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic_analyser_capture_if #(.WIDTH(WIDTH)) bus ();

  logic_analyser_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] hist [$];

  // Samples seen since the last reset edge, one per clock edge.
  function automatic logic [WIDTH-1:0] model_out();
    int t = -1;
    int n;
    logic [WIDTH-1:0] p = '0;
    n = hist.size() - 1;
    if (n < 0) return '0;
    for (int i = 0; i <= n; i++) begin
      if (hist[i] != p) begin
        t = i;
        break;
      end
      p = hist[i];
    end
    if (t < 0) return hist[n];
    return hist[t + ((n - t) % DEPTH)];
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: io_out0=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [WIDTH-1:0] v, input logic r);
    bus.io_in0 = v;
    reset = r;
    @(posedge clk);
    if (r) hist.delete();
    else hist.push_back(v);
    #1;
    check("model", bus.io_out0, model_out());
  endtask

  initial begin
    bus.io_in0 = '0;
    @(negedge clk);
    step(4'h0, 1'b1);
    step(4'h0, 1'b1);
    check("reset_out", bus.io_out0, 4'h0);

    // Constant zero never triggers.
    for (int i = 0; i < 20; i++) step(4'h0, 1'b0);
    check("idle_zero", bus.io_out0, 4'h0);

    // Incrementing pattern starting at 5.
    for (int i = 0; i < 16; i++) begin
      step(4'((5 + i) % 16), 1'b0);
      if (i == 0) check("monitor_delay", bus.io_out0, 4'h5);
      if (i == 15) check("last_capture", bus.io_out0, 4'h4);
    end
    for (int i = 0; i < 40; i++) begin
      step(4'($urandom_range(0, 15)), 1'b0);
      if (i == 0) check("first_replay", bus.io_out0, 4'h5);
      if (i == 10) check("replay_mid", bus.io_out0, 4'hF);
      if (i == 16) check("replay_wrap", bus.io_out0, 4'h5);
      if (i == 31) check("replay_end", bus.io_out0, 4'h4);
    end

    // Reset mid-capture, then a fresh capture starting at 9.
    step(4'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(4'(3 + i), 1'b0);
    step(4'h7, 1'b1);
    check("abort_reset", bus.io_out0, 4'h0);
    step(4'h0, 1'b0);
    for (int i = 0; i < 16; i++) step(4'((9 + i) % 16), 1'b0);
    step(4'h2, 1'b0);
    check("fresh_replay", bus.io_out0, 4'h9);
    step(4'h2, 1'b0);
    check("fresh_replay2", bus.io_out0, 4'hA);

    // Constant 0xA window, then reset with 0xA held retriggers immediately.
    step(4'h0, 1'b1);
    for (int i = 0; i < 36; i++) step(4'hA, 1'b0);
    check("const_replay", bus.io_out0, 4'hA);
    step(4'hA, 1'b1);
    check("const_reset", bus.io_out0, 4'h0);
    for (int i = 0; i < 16; i++) step(4'hA, 1'b0);
    for (int i = 0; i < 8; i++) step(4'h5, 1'b0);
    check("const_retrigger", bus.io_out0, 4'hA);

    // Back-to-back changes 3,3,9 right after reset.
    step(4'h0, 1'b1);
    step(4'h3, 1'b0);
    step(4'h3, 1'b0);
    step(4'h9, 1'b0);
    for (int i = 0; i < 13; i++) step(4'h0, 1'b0);
    step(4'hF, 1'b0);
    check("seq_mem0", bus.io_out0, 4'h3);
    step(4'hF, 1'b0);
    check("seq_mem1", bus.io_out0, 4'h3);
    step(4'hF, 1'b0);
    check("seq_mem2", bus.io_out0, 4'h9);
    step(4'hF, 1'b0);
    check("seq_mem3", bus.io_out0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_analyser_capture.md
Name: logic_analyser_capture

Overview:
- Minimal 4-bit logic-analyser channel: monitors a 4-bit probe bus and arms on reset.
- On the first value change it captures a fixed-depth window of consecutive samples, then replays that window cyclically on its output.
- Used as the leaf capture block of the logic-analyser subsystem and as a standalone smoke-test DUT.

Parameters:
- WIDTH, 4, probe/output bus width in bits.
- DEPTH, 16, number of samples captured per trigger; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in0  input  WIDTH  probe bus being sampled.
- io_out0  output  WIDTH  registered output: delayed probe in monitor mode, replayed capture in replay mode.

Behaviour:
- Registers:
  - state: ARMED / CAPTURE / REPLAY.
  - prev, WIDTH bits: last sample.
  - wr_ptr and rd_ptr, log2(DEPTH) bits each.
  - out_q drives io_out0.
  - Capture memory mem[DEPTH] x WIDTH.
- Reset, synchronous and active-high:
  - At a rising edge with reset=1: state=ARMED, prev=0, wr_ptr=0, rd_ptr=0, out_q=0.
  - mem contents are not cleared.
  - Reset overrides every other action, including mid-capture and mid-replay, which are aborted.
- ARMED:
  - Each edge: prev<=io_in0, out_q<=io_in0, so io_out0 is io_in0 delayed by one cycle.
  - Trigger condition: io_in0 != prev at an edge.
  - On trigger: mem[0]<=io_in0, wr_ptr<=1, state<=CAPTURE.
  - A constant 0 input after reset never triggers.
- CAPTURE:
  - Each edge: mem[wr_ptr]<=io_in0, prev<=io_in0, out_q<=io_in0, wr_ptr increments.
  - Further input changes are ignored as triggers.
  - On the edge that writes mem[DEPTH-1]: wr_ptr wraps to 0, rd_ptr<=0, state<=REPLAY.
  - Captured window = the trigger sample plus the next DEPTH-1 samples, exactly DEPTH consecutive edges.
- REPLAY:
  - Each edge: out_q<=mem[rd_ptr], rd_ptr<=rd_ptr+1, wrapping DEPTH-1 -> 0.
  - First REPLAY edge drives mem[0]; io_out0 then repeats the DEPTH-sample window indefinitely with period DEPTH.
  - io_in0 is ignored. Only reset leaves REPLAY.
- Latency:
  - Monitor path: 1 cycle.
  - Trigger edge to first replayed sample on io_out0: DEPTH+1 edges.
- No combinational path from io_in0 to io_out0.
- mem may be flops or a synchronous-write RAM. Read data must be registered into out_q as described, with no extra latency.

Test Plan:
- Reset with io_in0=0 held for 20 cycles -> io_out0=0 throughout; state stays ARMED.
- After reset, io_in0=5 at edge k, then 6, 7, ... (incrementing mod 16) -> io_out0 shows 5 at edge k (1-cycle delay).
  - From edge k+16, io_out0 shows 5, 6, 7, ..., 15, 0, ..., 4, then repeats 5... every 16 cycles.
- During REPLAY, drive random io_in0 -> io_out0 sequence unchanged; no retrigger.
- Assert reset for one edge mid-CAPTURE (after 8 samples) -> io_out0=0 next cycle; state ARMED.
  - A new change on io_in0 starts a fresh 16-sample capture whose replay begins with the new trigger value.
- Trigger with io_in0=0xA held constant -> replay outputs 0xA on every cycle.
  - Then reset with io_in0=0xA held -> first edge after reset retriggers (0xA != prev 0) and captures 0xA.
- Change io_in0 on every cycle in ARMED after reset (3, 3, 9) -> trigger on the first edge (3 != 0); mem[0]=3, mem[1]=3, mem[2]=9 confirmed in replay order.
